multicycle_controller: RTL

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/controller_pkg.sv | 80 ++++++++
 rtl/cond_check.sv | 33 +++
 rtl/multicycle_controller.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/controller_pkg.sv
// Shared types and select encodings for the multicycle controller.
package controller_pkg;

    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_EXEC   = 4'd2,
        ST_ALUWB  = 4'd3,
        ST_MEMADR = 4'd4,
        ST_MEMRD  = 4'd5,
        ST_MEMWB  = 4'd6,
        ST_MEMWR  = 4'd7,
        ST_BRANCH = 4'd8,
        ST_FAULT  = 4'd9
    } state_e;

    typedef enum logic [1:0] {
        OP_DP    = 2'b00,
        OP_MEM   = 2'b01,
        OP_BR    = 2'b10,
        OP_UNDEF = 2'b11
    } op_e;

    typedef enum logic [3:0] {
        CMD_AND = 4'b0000, CMD_EOR = 4'b0001, CMD_SUB = 4'b0010, CMD_RSB = 4'b0011,
        CMD_ADD = 4'b0100, CMD_ADC = 4'b0101, CMD_SBC = 4'b0110, CMD_RSC = 4'b0111,
        CMD_TST = 4'b1000, CMD_TEQ = 4'b1001, CMD_CMP = 4'b1010, CMD_CMN = 4'b1011,
        CMD_ORR = 4'b1100, CMD_MOV = 4'b1101, CMD_BIC = 4'b1110, CMD_MVN = 4'b1111
    } cmd_e;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_ADC = 4'd1;
    localparam logic [3:0] ALU_SUB = 4'd2;
    localparam logic [3:0] ALU_RSB = 4'd3;
    localparam logic [3:0] ALU_SBC = 4'd4;
    localparam logic [3:0] ALU_RSC = 4'd5;
    localparam logic [3:0] ALU_AND = 4'd7;
    localparam logic [3:0] ALU_EOR = 4'd8;
    localparam logic [3:0] ALU_ORR = 4'd9;
    localparam logic [3:0] ALU_MVN = 4'd10;
    localparam logic [3:0] ALU_BIC = 4'd11;
    localparam logic [3:0] ALU_MOV = 4'd12;

    localparam logic [3:0] SH_ROT_IMM  = 4'd0;
    localparam logic [3:0] SH_IMM_BASE = 4'd1;
    localparam logic [3:0] SH_RRX      = 4'd5;
    localparam logic [3:0] SH_REG_BASE = 4'd6;

    function automatic logic [3:0] alu_sel_for(cmd_e cmd);
        case (cmd)
            CMD_AND, CMD_TST: return ALU_AND;
            CMD_EOR, CMD_TEQ: return ALU_EOR;
            CMD_SUB, CMD_CMP: return ALU_SUB;
            CMD_RSB:          return ALU_RSB;
            CMD_ADD, CMD_CMN: return ALU_ADD;
            CMD_ADC:          return ALU_ADC;
            CMD_SBC:          return ALU_SBC;
            CMD_RSC:          return ALU_RSC;
            CMD_ORR:          return ALU_ORR;
            CMD_MOV:          return ALU_MOV;
            CMD_BIC:          return ALU_BIC;
            CMD_MVN:          return ALU_MVN;
            default:          return ALU_ADD;
        endcase
    endfunction

    // ROR by an immediate of zero is the RRX encoding.
    function automatic logic [3:0] shift_sel(logic imm, logic reg_shift, logic [1:0] typ,
                                             logic [4:0] shamt);
        if (imm)
            return SH_ROT_IMM;
        else if (reg_shift)
            return SH_REG_BASE + {2'b00, typ};
        else if (typ == 2'b11 && shamt == 5'd0)
            return SH_RRX;
        else
            return SH_IMM_BASE + {2'b00, typ};
    endfunction

endpackage

// File: rtl/cond_check.sv
// ARM condition-code evaluation against NZCV flags.
module cond_check (
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic n, z, c, v;
    assign {n, z, c, v} = flags;

    always_comb begin
        pass = 1'b0;
        case (cond)
            4'b0000: pass = z;
            4'b0001: pass = ~z;
            4'b0010: pass = c;
            4'b0011: pass = ~c;
            4'b0100: pass = n;
            4'b0101: pass = ~n;
            4'b0110: pass = v;
            4'b0111: pass = ~v;
            4'b1000: pass = c & ~z;
            4'b1001: pass = ~c | z;
            4'b1010: pass = (n == v);
            4'b1011: pass = (n != v);
            4'b1100: pass = ~z & (n == v);
            4'b1101: pass = z | (n != v);
            4'b1110: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle ARM-subset control FSM with memory-wait timeout and sticky fault.
module multicycle_controller
    import controller_pkg::*;
#(
    parameter int unsigned TIMEOUT_W = 4,
    parameter int unsigned ALU_SEL_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          instr,
    input  logic [3:0]           alu_flags,
    input  logic                 imem_ready,
    input  logic                 dmem_ready,
    output logic                 imem_req,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic                 ir_wen,
    output logic                 pc_wen,
    output logic                 pc_src,
    output logic                 regFile_wen,
    output logic [ALU_SEL_W-1:0] sALU,
    output logic [3:0]           sShifter,
    output logic [1:0]           ssrc1Mux,
    output logic [3:0]           flags,
    output logic                 fault,
    output logic [3:0]           state
);

    localparam int unsigned WAIT_LIMIT = (1 << TIMEOUT_W) - 1;

    state_e               state_q, state_d;
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic [3:0]           flags_q, flags_d;
    logic                 fault_q, fault_d;

    logic cond_pass;
    logic wait_expired;
    logic is_compare;
    cmd_e cmd;
    op_e  op;

    logic unused_instr_c;
    assign unused_instr_c = ^{instr[22], instr[19:12], instr[3:0]};

    assign cmd          = cmd_e'(instr[24:21]);
    assign op           = op_e'(instr[27:26]);
    assign is_compare   = (instr[24:23] == 2'b10);
    assign wait_expired = (cnt_q == TIMEOUT_W'(WAIT_LIMIT - 1));

    cond_check u_cond_check (
        .cond  (instr[31:28]),
        .flags (flags_q),
        .pass  (cond_pass)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            cnt_q   <= '0;
            flags_q <= 4'b0000;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            flags_q <= flags_d;
            fault_q <= fault_d;
        end
    end

    // Next state, wait counter, flag capture and sticky fault.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        flags_d = flags_q;
        case (state_q)
            ST_FETCH: begin
                if (imem_ready)        state_d = ST_DECODE;
                else if (wait_expired) state_d = ST_FAULT;
                else                   cnt_d   = cnt_q + TIMEOUT_W'(1);
            end
            ST_DECODE: begin
                if (!cond_pass) state_d = ST_FETCH;
                else begin
                    case (op)
                        OP_DP:   state_d = ST_EXEC;
                        OP_MEM:  state_d = ST_MEMADR;
                        OP_BR:   state_d = ST_BRANCH;
                        default: state_d = ST_FAULT;
                    endcase
                end
            end
            ST_EXEC: begin
                if (instr[20] || is_compare) flags_d = alu_flags;
                state_d = is_compare ? ST_FETCH : ST_ALUWB;
            end
            ST_ALUWB:  state_d = ST_FETCH;
            ST_MEMADR: state_d = instr[20] ? ST_MEMRD : ST_MEMWR;
            ST_MEMRD: begin
                if (dmem_ready)        state_d = ST_MEMWB;
                else if (wait_expired) state_d = ST_FAULT;
                else                   cnt_d   = cnt_q + TIMEOUT_W'(1);
            end
            ST_MEMWB: state_d = ST_FETCH;
            ST_MEMWR: begin
                if (dmem_ready)        state_d = ST_FETCH;
                else if (wait_expired) state_d = ST_FAULT;
                else                   cnt_d   = cnt_q + TIMEOUT_W'(1);
            end
            ST_BRANCH: state_d = ST_FETCH;
            ST_FAULT:  state_d = ST_FAULT;
            default:   state_d = ST_FAULT;
        endcase
        if (state_d != state_q) cnt_d = '0;
        fault_d = fault_q | (state_d == ST_FAULT);
    end

    // Datapath controls; everything is forced low while reset is asserted.
    always_comb begin
        imem_req    = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        ir_wen      = 1'b0;
        pc_wen      = 1'b0;
        pc_src      = 1'b0;
        regFile_wen = 1'b0;
        sALU        = '0;
        sShifter    = 4'd0;
        ssrc1Mux    = 2'b00;
        if (rst_n) begin
            case (state_q)
                ST_FETCH: begin
                    imem_req = 1'b1;
                    ir_wen   = imem_ready;
                    pc_wen   = imem_ready;
                end
                ST_EXEC: begin
                    sALU     = ALU_SEL_W'(alu_sel_for(cmd));
                    sShifter = shift_sel(instr[25], instr[4], instr[6:5], instr[11:7]);
                end
                ST_ALUWB:  regFile_wen = 1'b1;
                ST_MEMADR: sALU = instr[23] ? ALU_SEL_W'(ALU_ADD) : ALU_SEL_W'(ALU_SUB);
                ST_MEMRD:  dmem_req = 1'b1;
                ST_MEMWB:  regFile_wen = 1'b1;
                ST_MEMWR: begin
                    dmem_req = 1'b1;
                    dmem_we  = 1'b1;
                end
                ST_BRANCH: begin
                    pc_wen      = 1'b1;
                    pc_src      = 1'b1;
                    ssrc1Mux    = 2'b01;
                    sALU        = ALU_SEL_W'(ALU_ADD);
                    regFile_wen = instr[24];
                end
                default: ;
            endcase
        end
    end

    assign flags = flags_q;
    assign fault = fault_q;
    assign state = state_q;

endmodule
